multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Main controller for the multicycle RV32I datapath; it is the producer side of every datapath select bus.
- Decodes the latched instruction, sequences the multi-cycle state machine, and drives the 2-bit and 1-bit select codes consumed by the datapath multiplexers.
- Also drives the register/memory/PC/IR write enables, ALU control and immediate-format select.
- Sits between the instruction register and the datapath; one instance per core.

Parameters:
- MEM_WAIT_EN, 1, when 1 FETCH/MEMREAD/MEMWRITE hold until mem_ready=1; when 0 mem_ready is ignored (treated as 1).

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle
- pc_write  out  1  pc_update | (branch & zero)
- adr_src  out  1  0=PC, 1=Result
- mem_write  out  1  data memory write enable
- ir_write  out  1  instruction/OldPC register load
- result_src  out  2  00=ALUOut, 01=Data, 10=ALUResult
- alu_src_a  out  2  00=PC, 01=OldPC, 10=RD1 register
- alu_src_b  out  2  00=RD2 register, 01=ImmExt, 10=constant 4
- imm_src  out  2  00=I, 01=S, 10=B, 11=J
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- reg_write  out  1  register file write enable
- illegal_op  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- State register updates on rising clk. reset=1 at an edge forces FETCH, from any state, including mid-instruction.
- While reset=1, pc_write, ir_write, mem_write, reg_write and illegal_op are forced 0. Other outputs take their FETCH values: adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10, alu_control=000.
- Outputs are Moore, decoded combinationally from state. The only exception is the mem_ready gating described under FETCH below.
- States and outputs (unlisted = 0 / 00):
  - FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, aluop=00, result_src=10; ir_write and pc_update=mem_ready. Advances to DECODE only when mem_ready=1, otherwise holds.
  - DECODE: alu_src_a=01, alu_src_b=01, aluop=00 (branch target into ALUOut). Next state by op:
    - 0000011/0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other op -> FETCH with illegal_op=1 for this cycle.
  - MEMADR: alu_src_a=10, alu_src_b=01, aluop=00. Goes to MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD: result_src=00, adr_src=1. Waits for mem_ready, then MEMWB.
  - MEMWB: result_src=01, reg_write=1. Then FETCH.
  - MEMWRITE: result_src=00, adr_src=1, mem_write=1 held. Waits for mem_ready, then FETCH.
  - EXECUTER: alu_src_a=10, alu_src_b=00, aluop=10. Then ALUWB.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, aluop=10. Then ALUWB.
  - ALUWB: result_src=00, reg_write=1. Then FETCH.
  - BEQ: alu_src_a=10, alu_src_b=00, aluop=01, result_src=00, branch=1. Then FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, aluop=00, result_src=00, pc_update=1. Then ALUWB.
- Latency with mem_ready tied 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - I-type: 4 cycles
  - beq: 3 cycles
  - jal: 4 cycles
- imm_src is combinational from op:
  - I for 0000011/0010011
  - S for 0100011
  - B for 1100011
  - J for 1101111
  - 00 otherwise
- alu_control is derived from aluop:
  - aluop=00 -> add
  - aluop=01 -> sub
  - aluop=10, funct3 000: sub if op[5]&funct7b5, else add
  - aluop=10, other funct3: 010 slt, 110 or, 111 and
  - aluop=10, any other funct3: add.
- Never drive the reserved select code 11 on result_src, alu_src_a or alu_src_b.

Decomposition:
- Shared package: state enum (4-bit), opcode constants, select-code constants (RESULT_*, SRCA_*, SRCB_*, IMM_*), ALUOP_* and ALUCTL_* constants. Both this block and the datapath use the package.
- One sub-module, multicycle_alu_decoder: combinational aluop/funct3/funct7b5/op5 -> alu_control.

Test Plan:
- lw x1,4(x0) = 0x00402083, mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 only in cycle 5 with result_src=01. imm_src=00.
- sw = 0x0020A223, mem_ready low for 3 cycles in MEMWRITE -> mem_write held 1 for 4 cycles, then FETCH. reg_write never 1.
- add x3,x1,x2 = 0x002081B3 -> EXECUTER with alu_control=000. sub = 0x402081B3 gives 001. ALUWB reg_write=1.
- beq x0,x0 (op 1100011): zero=1 -> pc_write=1 in BEQ. zero=0 -> pc_write=0. Next state FETCH either way.
- jal (op 1101111) -> JAL: pc_write=1, alu_src_a=01, alu_src_b=10, then ALUWB reg_write=1. imm_src=11.
- op=1111111 -> illegal_op one-cycle pulse in DECODE, return to FETCH. Separately, reset asserted in MEMWRITE -> next state FETCH and all write enables 0 while reset high.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multicycle RV32I controller and datapath:
// state encoding, opcodes, mux select codes, ALU op classes and ALU controls.
package multicycle_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] RESULT_ALUOUT = 2'b00;
  localparam logic [1:0] RESULT_DATA   = 2'b01;
  localparam logic [1:0] RESULT_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUCTL_ADD = 3'b000;
  localparam logic [2:0] ALUCTL_SUB = 3'b001;
  localparam logic [2:0] ALUCTL_AND = 3'b010;
  localparam logic [2:0] ALUCTL_OR  = 3'b011;
  localparam logic [2:0] ALUCTL_SLT = 3'b101;

  // Immediate format for an opcode; unknown opcodes fall back to I.
  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_ITYPE: imm_sel = IMM_I;
      OP_STORE:          imm_sel = IMM_S;
      OP_BRANCH:         imm_sel = IMM_B;
      OP_JAL:            imm_sel = IMM_J;
      default:           imm_sel = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_alu_decoder.sv
// ALU control decode: turns the FSM's op class plus instruction fields into
// the 3-bit ALU operation.
module multicycle_alu_decoder
  import multicycle_control_fsm_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  // Address/branch classes are fixed; funct class decodes funct3 (sub only for R-type).
  always_comb begin
    alu_control = ALUCTL_ADD;
    case (aluop)
      ALUOP_ADD: alu_control = ALUCTL_ADD;
      ALUOP_SUB: alu_control = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? ALUCTL_SUB : ALUCTL_ADD;
          3'b010:  alu_control = ALUCTL_SLT;
          3'b110:  alu_control = ALUCTL_OR;
          3'b111:  alu_control = ALUCTL_AND;
          default: alu_control = ALUCTL_ADD;
        endcase
      end
      default: alu_control = ALUCTL_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I main controller: sequences instruction phases and drives
// every datapath select and write enable. Outputs are Moore except that the
// FETCH-phase PC/IR loads follow mem_ready.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       reg_write,
  output logic       illegal_op
);

  state_e     state_q, state_d;
  logic       mem_rdy;
  logic [1:0] aluop;
  logic       branch, pc_update;
  logic       adr_src_s, mem_write_s, ir_write_s, reg_write_s, illegal_s;
  logic [1:0] result_src_s, alu_src_a_s, alu_src_b_s;

  // Without wait support the memory is assumed to finish every access at once.
  assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign imm_src = imm_sel(op);

  // State register; reset returns to FETCH from anywhere.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_rdy ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state select codes and enables; reset overrides with quiet FETCH values.
  always_comb begin
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    illegal_s    = 1'b0;
    branch       = 1'b0;
    pc_update    = 1'b0;
    aluop        = ALUOP_ADD;
    result_src_s = RESULT_ALUOUT;
    alu_src_a_s  = SRCA_PC;
    alu_src_b_s  = SRCB_RD2;
    case (state_q)
      S_FETCH: begin
        alu_src_b_s  = SRCB_FOUR;
        result_src_s = RESULT_ALURES;
        ir_write_s   = mem_rdy;
        pc_update    = mem_rdy;
      end
      S_DECODE: begin
        alu_src_a_s = SRCA_OLDPC;
        alu_src_b_s = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: illegal_s = 1'b0;
          default: illegal_s = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s = SRCA_RD1;
        alu_src_b_s = SRCB_IMM;
      end
      S_MEMREAD:  adr_src_s = 1'b1;
      S_MEMWB: begin
        result_src_s = RESULT_DATA;
        reg_write_s  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a_s = SRCA_RD1;
        aluop       = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        alu_src_a_s = SRCA_RD1;
        alu_src_b_s = SRCB_IMM;
        aluop       = ALUOP_FUNCT;
      end
      S_ALUWB:    reg_write_s = 1'b1;
      S_BEQ: begin
        alu_src_a_s = SRCA_RD1;
        aluop       = ALUOP_SUB;
        branch      = 1'b1;
      end
      S_JAL: begin
        alu_src_a_s = SRCA_OLDPC;
        alu_src_b_s = SRCB_FOUR;
        pc_update   = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      adr_src_s    = 1'b0;
      mem_write_s  = 1'b0;
      ir_write_s   = 1'b0;
      reg_write_s  = 1'b0;
      illegal_s    = 1'b0;
      branch       = 1'b0;
      pc_update    = 1'b0;
      aluop        = ALUOP_ADD;
      result_src_s = RESULT_ALURES;
      alu_src_a_s  = SRCA_PC;
      alu_src_b_s  = SRCB_FOUR;
    end
  end

  assign pc_write   = pc_update | (branch & zero);
  assign adr_src    = adr_src_s;
  assign mem_write  = mem_write_s;
  assign ir_write   = ir_write_s;
  assign reg_write  = reg_write_s;
  assign illegal_op = illegal_s;
  assign result_src = result_src_s;
  assign alu_src_a  = alu_src_a_s;
  assign alu_src_b  = alu_src_b_s;

  multicycle_alu_decoder u_alu_dec (
    .aluop       (aluop),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for the multicycle controller: each test queues per-cycle stimulus
// {reset, zero, mem_ready} and the expected output vector, then walks the
// queues one clock at a time comparing outputs at the falling edge.
module tb_multicycle_control_fsm;

  localparam int W = 17;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;

  logic [W-1:0] exp_q[$];
  logic [2:0]   stim_q[$];
  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] outs;
  assign outs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                 alu_src_b, imm_src, alu_control, reg_write, illegal_op};

  multicycle_control_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .reg_write   (reg_write),
    .illegal_op  (illegal_op)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected output vector built field by field
  function automatic logic [W-1:0] v(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] imm, input logic [2:0] ac,
                                     input logic rw, input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, imm, ac, rw, ill};
  endfunction

  // Driver tasks
  task automatic set_instr(input logic [31:0] ins);
    op       = ins[6:0];
    funct3   = ins[14:12];
    funct7b5 = ins[30];
  endtask

  task automatic push(input logic [2:0] stim, input logic [W-1:0] e);
    stim_q.push_back(stim);
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [2:0] s; logic [W-1:0] e; int cyc = 0;
    set_instr(32'h00402083);
    push(3'b101, v(0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    push(3'b111, v(0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); {reset, zero, mem_ready} = s;
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (outs !== e) begin
        n_err++; $display("FAIL reset cyc%0d: got %h expected %h", cyc, outs, e);
      end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    logic [2:0] s; logic [W-1:0] e; int cyc = 0;
    set_instr(32'h00402083);
    push(3'b001, v(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0)); // FETCH
    push(3'b001, v(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0)); // DECODE
    push(3'b001, v(0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0)); // MEMADR
    push(3'b001, v(0,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0)); // MEMREAD
    push(3'b001, v(0,0,0,0,2'b01,2'b00,2'b00,2'b00,3'b000,1,0)); // MEMWB
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); {reset, zero, mem_ready} = s;
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (outs !== e) begin
        n_err++; $display("FAIL lw cyc%0d: got %h expected %h", cyc, outs, e);
      end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_wait();
    logic [2:0] s; logic [W-1:0] e; int cyc = 0;
    set_instr(32'h0020A223);
    push(3'b001, v(1,0,0,1,2'b10,2'b00,2'b10,2'b01,3'b000,0,0)); // FETCH
    push(3'b001, v(0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0,0)); // DECODE
    push(3'b001, v(0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0,0)); // MEMADR
    for (int i = 0; i < 4; i++)                                  // MEMWRITE x4
      push((i == 3) ? 3'b001 : 3'b000, v(0,1,1,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0));
    push(3'b000, v(0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0)); // FETCH stalled
    push(3'b000, v(0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0)); // FETCH stalled
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); {reset, zero, mem_ready} = s;
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (outs !== e) begin
        n_err++; $display("FAIL sw cyc%0d: got %h expected %h", cyc, outs, e);
      end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_ops();
    logic [2:0] s; logic [W-1:0] e; int cyc = 0;
    logic [31:0] ins [6];
    logic [2:0]  ac  [6];
    ins[0] = 32'h002081B3; ac[0] = 3'b000; // add
    ins[1] = 32'h402081B3; ac[1] = 3'b001; // sub
    ins[2] = 32'h0020F1B3; ac[2] = 3'b010; // and
    ins[3] = 32'h0020A1B3; ac[3] = 3'b101; // slt
    ins[4] = 32'h4050E193; ac[4] = 3'b011; // ori
    ins[5] = 32'h40508193; ac[5] = 3'b000; // addi with bit30 set: still add
    for (int k = 0; k < 6; k++) begin
      logic [1:0] sb;
      set_instr(ins[k]);
      sb = (ins[k][5]) ? 2'b00 : 2'b01;
      push(3'b001, v(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
      push(3'b001, v(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
      push(3'b001, v(0,0,0,0,2'b00,2'b10,sb,2'b00,ac[k],0,0));
      push(3'b001, v(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1,0));
      while (exp_q.size() > 0) begin
        s = stim_q.pop_front(); {reset, zero, mem_ready} = s;
        @(negedge clk);
        e = exp_q.pop_front(); n_cmp++;
        if (outs !== e) begin
          n_err++; $display("FAIL alu%0d cyc%0d: got %h expected %h", k, cyc, outs, e);
        end
        cyc++; @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_beq();
    logic [2:0] s; logic [W-1:0] e; int cyc = 0;
    set_instr(32'h00000463);
    for (int z = 1; z >= 0; z--) begin
      logic zb;
      zb = (z == 1);
      push({1'b0, zb, 1'b1}, v(1,0,0,1,2'b10,2'b00,2'b10,2'b10,3'b000,0,0));
      push({1'b0, zb, 1'b1}, v(0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0,0));
      push({1'b0, zb, 1'b1}, v(zb,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0,0));
    end
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); {reset, zero, mem_ready} = s;
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (outs !== e) begin
        n_err++; $display("FAIL beq cyc%0d: got %h expected %h", cyc, outs, e);
      end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_jal();
    logic [2:0] s; logic [W-1:0] e; int cyc = 0;
    set_instr(32'h008000EF);
    push(3'b011, v(1,0,0,1,2'b10,2'b00,2'b10,2'b11,3'b000,0,0)); // FETCH
    push(3'b011, v(0,0,0,0,2'b00,2'b01,2'b01,2'b11,3'b000,0,0)); // DECODE
    push(3'b001, v(1,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000,0,0)); // JAL
    push(3'b011, v(0,0,0,0,2'b00,2'b00,2'b00,2'b11,3'b000,1,0)); // ALUWB
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); {reset, zero, mem_ready} = s;
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (outs !== e) begin
        n_err++; $display("FAIL jal cyc%0d: got %h expected %h", cyc, outs, e);
      end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [2:0] s; logic [W-1:0] e; int cyc = 0;
    set_instr(32'h0000007F);
    push(3'b001, v(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0)); // FETCH
    push(3'b001, v(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,1)); // DECODE, pulse
    push(3'b000, v(0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0)); // back in FETCH
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); {reset, zero, mem_ready} = s;
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (outs !== e) begin
        n_err++; $display("FAIL illegal cyc%0d: got %h expected %h", cyc, outs, e);
      end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] s; logic [W-1:0] e; int cyc = 0;
    set_instr(32'h0020A223);
    push(3'b001, v(1,0,0,1,2'b10,2'b00,2'b10,2'b01,3'b000,0,0)); // FETCH
    push(3'b001, v(0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0,0)); // DECODE
    push(3'b001, v(0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0,0)); // MEMADR
    push(3'b000, v(0,1,1,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0)); // MEMWRITE stalled
    push(3'b101, v(0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0)); // reset held
    push(3'b001, v(1,0,0,1,2'b10,2'b00,2'b10,2'b01,3'b000,0,0)); // FETCH after reset
    push(3'b001, v(0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0,0)); // DECODE
    push(3'b001, v(0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0,0)); // MEMADR
    push(3'b001, v(0,1,1,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0)); // MEMWRITE
    push(3'b000, v(0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0)); // FETCH stalled
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); {reset, zero, mem_ready} = s;
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (outs !== e) begin
        n_err++; $display("FAIL reset_mid cyc%0d: got %h expected %h", cyc, outs, e);
      end
      cyc++; @(posedge clk); #1;
    end
  endtask

  // Test sequence and final report
  initial begin
    reset = 1'b1; zero = 1'b0; mem_ready = 1'b1;
    op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_lw();
    test_sw_wait();
    test_alu_ops();
    test_beq();
    test_jal();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
